traceback_engine: RTL and testbench
===================================

TRACEBACK_ENGINE -- requirements
Module: traceback_engine

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- N, 128, sequence length; the matrix indices run 0..N.
- BitAddr, $clog2(N+1), index width.
- SYM_W, 3, residue symbol width.
- GAP_SYM, 3'b100, symbol emitted for a gap.
- MATCH, 1; MISMATCH, -1; GAP, -2; signed step scores.
- SCORE_W, 12, signed score width.
- RD_LAT, 1, RAM read latency in cycles; legal values are 1..4.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  the single clock.
- rst  in  1  asynchronous reset, active-low (rst=0 resets).
- start  in  1  one-cycle pulse that begins a traceback.
- dir_rd_en  out  1  direction-RAM read strobe.
- dir_i, dir_j  out  BitAddr  direction-RAM cell address.
- dir_data  in  2  direction code: 00 diag, 01 up, 10 left, 11 stop.
- seqA_addr, seqB_addr  out  BitAddr  sequence-RAM addresses i-1 and j-1.
- seqA_data, seqB_data  in  SYM_W  sequence residues.
- out_valid  out  1  an alignment beat is present.
- out_ready  in  1  the sink accepts the beat.
- out_a, out_b  out  SYM_W  aligned symbol pair.
- out_op  out  2  direction applied for this beat.
- busy  out  1  a traceback is in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky illegal-stop flag.
- final_score  out  SCORE_W  signed accumulated score.
- align_len  out  BitAddr+1  number of beats emitted.

Function
REQ-003 The FSM SHALL have the states IDLE, READ, WAIT, EMIT and DONE.
REQ-004 In IDLE, start=1 SHALL set i=N and j=N, clear final_score, align_len and error, assert busy, and go to READ.
REQ-005 A start pulse arriving outside IDLE SHALL be ignored.
REQ-006 In READ, the block SHALL assert dir_rd_en for one cycle with dir_i=i, dir_j=j, seqA_addr=i-1 and seqB_addr=j-1 (each address forced to 0 when its index is 0).
REQ-007 WAIT SHALL last RD_LAT-1 cycles, then go to EMIT; the RAM data SHALL be captured into internal registers on EMIT entry.
REQ-008 The effective direction SHALL be: left if i==0; up if j==0; otherwise the captured dir_data.
REQ-009 If the effective direction is 11 with i>0 and j>0, the block SHALL set error=1, emit no beat, and go to DONE.
REQ-010 In EMIT, out_valid SHALL be 1 and out_a, out_b and out_op SHALL be held stable until out_ready=1.
REQ-011 Beat contents SHALL be:
- diag: (seqA, seqB).
- up: (seqA, GAP_SYM).
- left: (GAP_SYM, seqB).
REQ-012 On the handshake cycle (out_valid & out_ready), the block SHALL:
- decrement i for diag/up and decrement j for diag/left;
- increment align_len;
- add to final_score: MATCH if diag and seqA==seqB, MISMATCH if diag and the residues differ, GAP if up/left.
REQ-013 The score addition SHALL saturate at the signed SCORE_W limits.
REQ-014 After the handshake, the FSM SHALL go to DONE if the updated (i,j)==(0,0), else to READ; out_valid SHALL deassert in the following cycle.
REQ-015 Beats SHALL be emitted in reverse order (from cell (N,N) back toward (0,0)); the maximum length is 2N.
REQ-016 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-017 final_score, align_len and error SHALL hold their values until the next accepted start.
REQ-018 Throughput SHALL be one beat per RD_LAT+1 cycles when out_ready is held at 1.
REQ-019 While out_ready=0, i, j, final_score and align_len SHALL remain unchanged.

Reset
REQ-020 While rst=0 (asynchronous), the block SHALL hold the FSM in IDLE and drive i=j=0 and every output to 0 (including out_valid, dir_rd_en, done, error, final_score and align_len), regardless of clk.
REQ-021 A reset asserted mid-traceback SHALL abort it with no done pulse; after rst rises, the block SHALL stay idle until a new start.

Verification (N=4, RD_LAT=1 unless stated)
REQ-022 A bench SHALL cover the following directed scenarios (stimulus -> required response):
- seqA=seqB=ACGT, all dir=00 -> 4 beats of matching pairs, final_score=4, align_len=4, one done pulse, error=0.
- All dir=01 -> 4 up beats with (i:4->0, j=4), then 4 forced-left beats; align_len=8, final_score=-16.
- Diag-only path with seqA=AAAA, seqB=AAAT -> first beat is a mismatch; final_score=2.
- out_ready=0 for 5 cycles during the 2nd beat -> out_valid held, out_a/out_b/out_op stable, the counters frozen, and the final results identical to the unstalled run.
- dir=11 returned at cell (2,3) -> error=1 and done pulses, the 11 cell produces no beat, align_len counts only the beats before it.
- start pulsed while busy is ignored; rst=0 in the 3rd beat's EMIT -> out_valid drops immediately, no done; a new start gives a clean full run (with RD_LAT=3 the beat spacing is 4 cycles).

Source files
------------

// File: rtl/traceback_engine.sv
// Alignment traceback: walks the direction matrix from (N,N) back to (0,0),
// emitting one aligned symbol pair per step with a saturating running score.
//
// state | meaning
// IDLE  | waiting for start
// READ  | strobe direction/sequence RAM at (i,j)
// WAIT  | remaining RAM latency (RD_LAT-1 cycles)
// EMIT  | present beat, hold until out_ready
// DONE  | one-cycle completion pulse
module traceback_engine #(
    parameter int               N        = 128,
    parameter int               BitAddr  = $clog2(N + 1),
    parameter int               SYM_W    = 3,
    parameter logic [SYM_W-1:0] GAP_SYM  = 3'b100,
    parameter int               MATCH    = 1,
    parameter int               MISMATCH = -1,
    parameter int               GAP      = -2,
    parameter int               SCORE_W  = 12,
    parameter int               RD_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      dir_rd_en,
    output logic [BitAddr-1:0]        dir_i,
    output logic [BitAddr-1:0]        dir_j,
    input  logic [1:0]                dir_data,
    output logic [BitAddr-1:0]        seqA_addr,
    output logic [BitAddr-1:0]        seqB_addr,
    input  logic [SYM_W-1:0]          seqA_data,
    input  logic [SYM_W-1:0]          seqB_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SYM_W-1:0]          out_a,
    output logic [SYM_W-1:0]          out_b,
    output logic [1:0]                out_op,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic signed [SCORE_W-1:0] final_score,
    output logic [BitAddr:0]          align_len
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;

    localparam logic [1:0] DIR_DIAG = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_LEFT = 2'b10;
    localparam logic [1:0] DIR_STOP = 2'b11;
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

    state_t                      r_state;
    state_t                      w_next;
    logic [BitAddr-1:0]          r_i;
    logic [BitAddr-1:0]          r_j;
    logic [1:0]                  r_wait;
    logic                        r_first;
    logic [1:0]                  r_dir;
    logic [SYM_W-1:0]            r_sa;
    logic [SYM_W-1:0]            r_sb;
    logic signed [SCORE_W-1:0]   r_score;
    logic [BitAddr:0]            r_len;
    logic                        r_error;

    logic [1:0]                  w_dir_raw;
    logic [1:0]                  w_eff;
    logic [SYM_W-1:0]            w_sa;
    logic [SYM_W-1:0]            w_sb;
    logic                        w_stop;
    logic                        w_fire;
    logic [BitAddr-1:0]          w_i_next;
    logic [BitAddr-1:0]          w_j_next;
    logic signed [SCORE_W:0]     w_step;
    logic signed [SCORE_W:0]     w_sum;
    logic signed [SCORE_W-1:0]   w_score_sat;

    // RAM data is live only in the first EMIT cycle; later cycles use the capture
    assign w_dir_raw = r_first ? dir_data  : r_dir;
    assign w_sa      = r_first ? seqA_data : r_sa;
    assign w_sb      = r_first ? seqB_data : r_sb;

    always_comb begin
        w_eff = w_dir_raw;
        if (r_i == '0) begin
            w_eff = DIR_LEFT;
        end else if (r_j == '0) begin
            w_eff = DIR_UP;
        end
    end

    assign w_stop   = (w_eff == DIR_STOP);
    assign w_fire   = (r_state == EMIT) && !w_stop && out_ready;
    assign w_i_next = (w_eff == DIR_DIAG || w_eff == DIR_UP)   ? r_i - BitAddr'(1) : r_i;
    assign w_j_next = (w_eff == DIR_DIAG || w_eff == DIR_LEFT) ? r_j - BitAddr'(1) : r_j;

    always_comb begin
        w_step = (SCORE_W + 1)'(GAP);
        if (w_eff == DIR_DIAG) begin
            w_step = (w_sa == w_sb) ? (SCORE_W + 1)'(MATCH) : (SCORE_W + 1)'(MISMATCH);
        end
    end

    assign w_sum = {r_score[SCORE_W-1], r_score} + w_step;

    always_comb begin
        w_score_sat = w_sum[SCORE_W-1:0];
        if (w_sum[SCORE_W] != w_sum[SCORE_W-1]) begin
            w_score_sat = w_sum[SCORE_W] ? {1'b1, {(SCORE_W - 1){1'b0}}}
                                         : {1'b0, {(SCORE_W - 1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        dir_rd_en = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = READ;
                end
            end
            READ: begin
                dir_rd_en = 1'b1;
                busy      = 1'b1;
                w_next    = (RD_LAT > 1) ? WAIT : EMIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (r_wait == 2'd0) begin
                    w_next = EMIT;
                end
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = !w_stop;
                if (w_stop) begin
                    w_next = DONE;
                end else if (out_ready) begin
                    w_next = (w_i_next == '0 && w_j_next == '0) ? DONE : READ;
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i     <= '0;
            r_j     <= '0;
            r_wait  <= '0;
            r_first <= 1'b0;
            r_dir   <= '0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_score <= '0;
            r_len   <= '0;
            r_error <= 1'b0;
        end else begin
            r_first <= (r_state != EMIT) && (w_next == EMIT);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i     <= BitAddr'(N);
                        r_j     <= BitAddr'(N);
                        r_score <= '0;
                        r_len   <= '0;
                        r_error <= 1'b0;
                    end
                end
                READ: r_wait <= WAIT_INIT;
                WAIT: begin
                    if (r_wait != 2'd0) begin
                        r_wait <= r_wait - 2'd1;
                    end
                end
                EMIT: begin
                    if (r_first) begin
                        r_dir <= dir_data;
                        r_sa  <= seqA_data;
                        r_sb  <= seqB_data;
                    end
                    if (w_stop) begin
                        r_error <= 1'b1;
                    end else if (w_fire) begin
                        r_i     <= w_i_next;
                        r_j     <= w_j_next;
                        r_len   <= r_len + (BitAddr + 1)'(1);
                        r_score <= w_score_sat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dir_i       = r_i;
    assign dir_j       = r_j;
    assign seqA_addr   = (r_i == '0) ? '0 : r_i - BitAddr'(1);
    assign seqB_addr   = (r_j == '0) ? '0 : r_j - BitAddr'(1);
    assign out_a       = !out_valid ? '0 : (w_eff == DIR_LEFT) ? GAP_SYM : w_sa;
    assign out_b       = !out_valid ? '0 : (w_eff == DIR_UP)   ? GAP_SYM : w_sb;
    assign out_op      = out_valid ? w_eff : 2'b00;
    assign error       = r_error;
    assign final_score = r_score;
    assign align_len   = r_len;

endmodule

// File: tb/tb_traceback_engine.sv
// Directed bench for traceback_engine: two instances (RD_LAT=1 and RD_LAT=3),
// each fed by a behavioural direction/sequence RAM of matching latency.
module tb_traceback_engine;

    localparam int N  = 4;
    localparam int BA = 3;
    localparam int SW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst [2];
    logic              start [2];
    logic              dir_rd_en [2];
    logic              out_valid [2];
    logic              out_ready [2];
    logic              busy [2];
    logic              done [2];
    logic              error [2];
    logic [BA-1:0]     dir_i [2];
    logic [BA-1:0]     dir_j [2];
    logic [BA-1:0]     seqA_addr [2];
    logic [BA-1:0]     seqB_addr [2];
    logic [1:0]        dir_data [2];
    logic [1:0]        out_op [2];
    logic [SW-1:0]     seqA_data [2];
    logic [SW-1:0]     seqB_data [2];
    logic [SW-1:0]     out_a [2];
    logic [SW-1:0]     out_b [2];
    logic signed [11:0] final_score [2];
    logic [BA:0]       align_len [2];

    logic [1:0]        dir_mem [8][8];
    logic [SW-1:0]     seqA_mem [8];
    logic [SW-1:0]     seqB_mem [8];

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [1:0]    dpipe [LAT];
        logic          vpipe [LAT];
        logic [SW-1:0] apipe [LAT];
        logic [SW-1:0] bpipe [LAT];

        traceback_engine #(.N(N), .RD_LAT(LAT)) dut (
            .clk(clk), .rst(rst[k]), .start(start[k]),
            .dir_rd_en(dir_rd_en[k]), .dir_i(dir_i[k]), .dir_j(dir_j[k]),
            .dir_data(dir_data[k]),
            .seqA_addr(seqA_addr[k]), .seqB_addr(seqB_addr[k]),
            .seqA_data(seqA_data[k]), .seqB_data(seqB_data[k]),
            .out_valid(out_valid[k]), .out_ready(out_ready[k]),
            .out_a(out_a[k]), .out_b(out_b[k]), .out_op(out_op[k]),
            .busy(busy[k]), .done(done[k]), .error(error[k]),
            .final_score(final_score[k]), .align_len(align_len[k])
        );

        // Data is only valid RD_LAT cycles after the strobe; otherwise junk
        always @(posedge clk) begin
            dpipe[0] <= dir_mem[dir_i[k]][dir_j[k]];
            vpipe[0] <= dir_rd_en[k];
            apipe[0] <= seqA_mem[seqA_addr[k]];
            bpipe[0] <= seqB_mem[seqB_addr[k]];
            for (int s = 1; s < LAT; s++) begin
                dpipe[s] <= dpipe[s-1];
                vpipe[s] <= vpipe[s-1];
                apipe[s] <= apipe[s-1];
                bpipe[s] <= bpipe[s-1];
            end
        end
        assign dir_data[k]  = (vpipe[LAT-1] === 1'b1) ? dpipe[LAT-1] : 2'b11;
        assign seqA_data[k] = (vpipe[LAT-1] === 1'b1) ? apipe[LAT-1] : 3'b111;
        assign seqB_data[k] = (vpipe[LAT-1] === 1'b1) ? bpipe[LAT-1] : 3'b111;
    end

    int vectors = 0;
    int errs    = 0;

    int            nb;
    int            ndone;
    int            stall_seen;
    bit            stall_bad;
    logic          busy_at_done;
    logic [SW-1:0] ba [16];
    logic [SW-1:0] bb [16];
    logic [1:0]    bop [16];
    logic [BA-1:0] bi [16];
    logic [BA-1:0] bj [16];
    int            bcyc [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [1:0] d, input logic [11:0] sa, input logic [11:0] sb);
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) dir_mem[a][b] = d;
            seqA_mem[a] = 3'b000;
            seqB_mem[a] = 3'b000;
        end
        for (int a = 0; a < 4; a++) begin
            seqA_mem[a] = sa[3*a +: 3];
            seqB_mem[a] = sb[3*a +: 3];
        end
    endtask

    task automatic run_trace(input int k, input int stall_beat, input int stall_len,
                             input int restart_cyc, input int budget);
        logic [SW-1:0] ha, hb;
        logic [1:0]    hop;
        logic [BA:0]   hl;
        logic [11:0]   hs;
        logic [BA-1:0] hi, hj;
        int            done_c;
        nb = 0; ndone = 0; stall_seen = 0; stall_bad = 0; busy_at_done = 1'b1;
        done_c = -1;
        ha = '0; hb = '0; hop = '0; hl = '0; hs = '0; hi = '0; hj = '0;
        out_ready[k] = 1'b1;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        for (int c = 0; c < budget; c++) begin
            start[k] = (c == restart_cyc);
            if (out_valid[k] && nb == stall_beat && stall_seen < stall_len) begin
                out_ready[k] = 1'b0;
                if (stall_seen == 0) begin
                    ha = out_a[k]; hb = out_b[k]; hop = out_op[k];
                    hl = align_len[k]; hs = final_score[k]; hi = dir_i[k]; hj = dir_j[k];
                end else if (out_a[k] !== ha || out_b[k] !== hb || out_op[k] !== hop ||
                             align_len[k] !== hl || final_score[k] !== hs ||
                             dir_i[k] !== hi || dir_j[k] !== hj) begin
                    stall_bad = 1'b1;
                end
                stall_seen++;
            end else begin
                out_ready[k] = 1'b1;
            end
            if (out_valid[k] && out_ready[k]) begin
                if (stall_seen > 0 && nb == stall_beat &&
                    (out_a[k] !== ha || out_b[k] !== hb || out_op[k] !== hop))
                    stall_bad = 1'b1;
                if (nb < 16) begin
                    ba[nb] = out_a[k]; bb[nb] = out_b[k]; bop[nb] = out_op[k];
                    bi[nb] = dir_i[k]; bj[nb] = dir_j[k]; bcyc[nb] = c;
                end
                nb++;
            end
            if (done[k]) begin
                ndone++;
                if (done_c < 0) begin
                    done_c = c;
                    busy_at_done = busy[k];
                end
            end
            if (done_c >= 0 && c >= done_c + 3) break;
            @(negedge clk);
        end
        start[k] = 1'b0;
        out_ready[k] = 1'b1;
    endtask

    initial begin
        int cnt;
        rst[0] = 1'b0; rst[1] = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        out_ready[0] = 1'b1; out_ready[1] = 1'b1;
        fill(2'b00, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd3, 3'd2, 3'd1, 3'd0});
        @(negedge clk); @(negedge clk);

        chk("rst_out_valid",  32'(out_valid[0]), 32'd0);
        chk("rst_dir_rd_en",  32'(dir_rd_en[0]), 32'd0);
        chk("rst_done",       32'(done[0]), 32'd0);
        chk("rst_error",      32'(error[0]), 32'd0);
        chk("rst_score",      32'(final_score[0]), 32'd0);
        chk("rst_align_len",  32'(align_len[0]), 32'd0);
        chk("rst_dir_ij",     32'({dir_i[0], dir_j[0]}), 32'd0);
        chk("rst_busy_lat3",  32'(busy[1]), 32'd0);

        rst[0] = 1'b1; rst[1] = 1'b1;
        @(negedge clk);

        // ACGT vs ACGT, all diagonal
        run_trace(0, -1, 0, -1, 60);
        chk("diag_beats",   32'(nb), 32'd4);
        chk("diag_done",    32'(ndone), 32'd1);
        chk("diag_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("diag_score",   32'(final_score[0]), 32'd4);
        chk("diag_len",     32'(align_len[0]), 32'd4);
        chk("diag_error",   32'(error[0]), 32'd0);
        for (int b = 0; b < 4; b++)
            chk($sformatf("diag_beat%0d", b), 32'({ba[b], bb[b], bop[b]}),
                32'({3'(3 - b), 3'(3 - b), 2'b00}));
        chk("diag_spacing", 32'(bcyc[1] - bcyc[0]), 32'd2);

        // all up: 4 up beats then 4 forced-left beats
        fill(2'b01, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd3, 3'd2, 3'd1, 3'd0});
        run_trace(0, -1, 0, -1, 80);
        chk("up_beats", 32'(nb), 32'd8);
        chk("up_score", 32'(final_score[0]), 32'(-16));
        chk("up_len",   32'(align_len[0]), 32'd8);
        for (int b = 0; b < 4; b++)
            chk($sformatf("up_beat%0d", b), 32'({ba[b], bb[b], bop[b], bi[b], bj[b]}),
                32'({3'(3 - b), 3'b100, 2'b01, 3'(4 - b), 3'd4}));
        for (int b = 4; b < 8; b++)
            chk($sformatf("left_beat%0d", b), 32'({ba[b], bb[b], bop[b], bi[b], bj[b]}),
                32'({3'b100, 3'(7 - b), 2'b10, 3'd0, 3'(8 - b)}));

        // AAAA vs AAAT, diagonal, with a start pulse mid-run that must be ignored
        fill(2'b00, {3'd0, 3'd0, 3'd0, 3'd0}, {3'd3, 3'd0, 3'd0, 3'd0});
        run_trace(0, -1, 0, 3, 60);
        chk("mm_beats",  32'(nb), 32'd4);
        chk("mm_done",   32'(ndone), 32'd1);
        chk("mm_score",  32'(final_score[0]), 32'd2);
        chk("mm_beat0",  32'({ba[0], bb[0], bop[0]}), 32'({3'd0, 3'd3, 2'b00}));

        // stall 5 cycles on beat 1
        fill(2'b00, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd3, 3'd2, 3'd1, 3'd0});
        run_trace(0, 1, 5, -1, 80);
        chk("stall_cycles", 32'(stall_seen), 32'd5);
        chk("stall_stable", 32'(stall_bad), 32'd0);
        chk("stall_beats",  32'(nb), 32'd4);
        chk("stall_score",  32'(final_score[0]), 32'd4);
        chk("stall_len",    32'(align_len[0]), 32'd4);
        chk("stall_beat1",  32'({ba[1], bb[1], bop[1]}), 32'({3'd2, 3'd2, 2'b00}));
        chk("stall_gap",    32'(bcyc[1] - bcyc[0]), 32'd7);

        // stop code at (2,3): diag from (4,4), up from (3,3)
        fill(2'b00, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd3, 3'd2, 3'd1, 3'd0});
        dir_mem[3][3] = 2'b01;
        dir_mem[2][3] = 2'b11;
        run_trace(0, -1, 0, -1, 60);
        chk("stop_beats", 32'(nb), 32'd2);
        chk("stop_error", 32'(error[0]), 32'd1);
        chk("stop_done",  32'(ndone), 32'd1);
        chk("stop_len",   32'(align_len[0]), 32'd2);
        chk("stop_score", 32'(final_score[0]), 32'(-1));

        // RD_LAT=3 instance: ignored start, reset during third beat, clean rerun
        fill(2'b00, {3'd3, 3'd2, 3'd1, 3'd0}, {3'd3, 3'd2, 3'd1, 3'd0});
        cnt = 0;
        out_ready[1] = 1'b1;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        for (int c = 0; c < 80; c++) begin
            start[1] = (c == 1);
            if (out_valid[1] && cnt == 2) break;
            if (out_valid[1]) cnt++;
            @(negedge clk);
        end
        start[1] = 1'b0;
        out_ready[1] = 1'b0;
        chk("abort_reached", 32'(cnt), 32'd2);
        chk("abort_dir_i",   32'(dir_i[1]), 32'd2);
        #1 rst[1] = 1'b0;
        #1;
        chk("abort_valid",  32'(out_valid[1]), 32'd0);
        chk("abort_busy",   32'(busy[1]), 32'd0);
        chk("abort_len",    32'(align_len[1]), 32'd0);
        chk("abort_score",  32'(final_score[1]), 32'd0);
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done[1]) cnt++;
        end
        rst[1] = 1'b1;
        out_ready[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done[1] || busy[1] || dir_rd_en[1]) cnt++;
        end
        chk("abort_quiet", 32'(cnt), 32'd0);

        run_trace(1, -1, 0, -1, 80);
        chk("lat3_beats",  32'(nb), 32'd4);
        chk("lat3_done",   32'(ndone), 32'd1);
        chk("lat3_score",  32'(final_score[1]), 32'd4);
        chk("lat3_len",    32'(align_len[1]), 32'd4);
        chk("lat3_beat0",  32'({ba[0], bb[0], bop[0]}), 32'({3'd3, 3'd3, 2'b00}));
        chk("lat3_space1", 32'(bcyc[1] - bcyc[0]), 32'd4);
        chk("lat3_space3", 32'(bcyc[3] - bcyc[2]), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
